rf_write_arbiter: RTL and testbench

- Shares the register file's single write port between pipeline writeback (MEM_WB) and a long-latency unit (mul/div) returning results out of order with the pipeline.
- Buffers long-latency results in a small FIFO.
- Keeps a pending-write scoreboard and raises the ID-stage hazard stall for pending registers.
- Forces a writeback bubble when buffered results starve.

---
 rtl/rf_write_arbiter_pkg.sv | 32 +++
 rtl/rf_result_fifo.sv | 68 ++++++
 rtl/rf_write_arbiter.sv | 179 +++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_write_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : rf_write_arbiter_pkg                                     |
// | Purpose : Shared types and constants for the register-file write   |
// |           arbiter and its long-latency result buffer.              |
// | Contents: reg_idx_t     - architectural register index             |
// |           lu_result_t   - buffered long-latency result {rd, data}  |
// |           grant_src_e   - source owning the write port this cycle  |
// |           STARVE_LIMIT_DEFAULT - default forced-drain threshold     |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package rf_write_arbiter_pkg;

   localparam int REG_IDX_W            = 5;
   localparam int STARVE_LIMIT_DEFAULT = 4;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef struct packed {
      reg_idx_t    rd;
      logic [31:0] data;
   } lu_result_t;

   typedef enum logic [1:0] {
      GNT_NONE   = 2'd0,
      GNT_FIFO   = 2'd1,
      GNT_WB     = 2'd2,
      GNT_BYPASS = 2'd3
   } grant_src_e;

endpackage : rf_write_arbiter_pkg
`default_nettype wire

// File: rtl/rf_result_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : rf_result_fifo                                           |
// | Purpose : Small circular buffer holding long-latency results until |
// |           the register-file write port becomes free.              |
// | Ports   : clk_i, rst_i (sync, active-low)                          |
// |           push_i/data_i  - enqueue a result                        |
// |           pop_i/head_o   - dequeue / oldest entry                  |
// |           full_o, empty_o, count_o - occupancy status              |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module rf_result_fifo
   import rf_write_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  lu_result_t             data_i,
   input  logic                   pop_i,
   output lu_result_t             head_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);

   lu_result_t    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          push_ok;
   logic          pop_ok;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // A push while full is only legal when the head leaves in the same cycle.
   assign push_ok = push_i && (!full_o || pop_i);
   assign pop_ok  = pop_i && !empty_o;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule : rf_result_fifo
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : rf_write_arbiter                                         |
// | Purpose : Shares the single register-file write port between the   |
// |           MEM_WB writeback and an out-of-order long-latency unit,  |
// |           tracks pending destinations and raises ID hazard stalls. |
// | Ports   : clk_i, rst_i (sync, active-low)                          |
// |           wb_*_i        - pipeline writeback request               |
// |           lu_issue*_i   - long-latency op leaving ID               |
// |           lu_*_i/lu_ready_o - long-latency result handshake        |
// |           rs1_i, rs2_i, id_we_i, id_rd_i - ID-stage operands       |
// |           rf_*_o        - register-file write port                 |
// |           hazard_stall_o, drain_stall_o - pipeline control         |
// |           pending_o, fifo_count_o       - debug visibility         |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module rf_write_arbiter
   import rf_write_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        wb_we_i,
   input  reg_idx_t                    wb_rd_i,
   input  logic [31:0]                 wb_data_i,
   input  logic                        lu_issue_i,
   input  reg_idx_t                    lu_issue_rd_i,
   input  logic                        lu_valid_i,
   input  reg_idx_t                    lu_rd_i,
   input  logic [31:0]                 lu_data_i,
   output logic                        lu_ready_o,
   input  reg_idx_t                    rs1_i,
   input  reg_idx_t                    rs2_i,
   input  logic                        id_we_i,
   input  reg_idx_t                    id_rd_i,
   output logic                        rf_we_o,
   output reg_idx_t                    rf_rd_o,
   output logic [31:0]                 rf_wdata_o,
   output logic                        hazard_stall_o,
   output logic                        drain_stall_o,
   output logic [31:0]                 pending_o,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

   localparam int AGE_W = $clog2(STARVE_LIMIT) + 1;

   lu_result_t                  fifo_head;
   lu_result_t                  lu_result;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                        fifo_push;
   logic                        fifo_pop;
   logic                        wb_req;
   logic                        lu_wr;
   grant_src_e                  grant_src;

   logic [31:0]      pending_q, pending_d;
   logic [AGE_W-1:0] age_q, age_d;
   logic             drain_stall_q, drain_stall_d;

   assign lu_result = '{rd: lu_rd_i, data: lu_data_i};

   rf_result_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .data_i  (lu_result),
      .pop_i   (fifo_pop),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // A writeback to x0 is architecturally a no-op, so it never claims the port.
   assign wb_req     = wb_we_i && (wb_rd_i != '0);
   // No look-ahead on a same-cycle pop: readiness depends on occupancy only.
   assign lu_ready_o = rst_i && !fifo_full;

   always_comb begin
      grant_src = GNT_NONE;
      if (rst_i) begin
         if (drain_stall_q && !fifo_empty)   grant_src = GNT_FIFO;
         else if (wb_req)                    grant_src = GNT_WB;
         else if (!fifo_empty)               grant_src = GNT_FIFO;
         else if (lu_valid_i && lu_ready_o)  grant_src = GNT_BYPASS;
      end
   end

   always_comb begin
      rf_we_o    = 1'b0;
      rf_rd_o    = '0;
      rf_wdata_o = '0;
      case (grant_src)
         GNT_FIFO: begin
            rf_we_o    = 1'b1;
            rf_rd_o    = fifo_head.rd;
            rf_wdata_o = fifo_head.data;
         end
         GNT_WB: begin
            rf_we_o    = 1'b1;
            rf_rd_o    = wb_rd_i;
            rf_wdata_o = wb_data_i;
         end
         GNT_BYPASS: begin
            rf_we_o    = 1'b1;
            rf_rd_o    = lu_rd_i;
            rf_wdata_o = lu_data_i;
         end
         default: begin
            rf_we_o    = 1'b0;
         end
      endcase
   end

   assign fifo_pop  = (grant_src == GNT_FIFO);
   // A bypassed result goes straight to the port and must not also be queued.
   assign fifo_push = lu_valid_i && lu_ready_o && (grant_src != GNT_BYPASS);
   assign lu_wr     = (grant_src == GNT_FIFO) || (grant_src == GNT_BYPASS);

   // Clear first, then set, so an issue to the same index in the same cycle wins.
   always_comb begin
      pending_d = pending_q;
      if (lu_wr) pending_d[rf_rd_o] = 1'b0;
      if (lu_issue_i && (lu_issue_rd_i != '0)) pending_d[lu_issue_rd_i] = 1'b1;
      pending_d[0] = 1'b0;
   end

   // Age counts cycles the head sits un-granted; any pop restarts it.
   always_comb begin
      if (fifo_pop || fifo_empty) age_d = '0;
      else                        age_d = age_q + AGE_W'(1);
      drain_stall_d = !fifo_empty && !fifo_pop &&
                      (age_d == AGE_W'(STARVE_LIMIT - 1));
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         pending_q     <= '0;
         age_q         <= '0;
         drain_stall_q <= 1'b0;
      end else begin
         pending_q     <= pending_d;
         age_q         <= age_d;
         drain_stall_q <= drain_stall_d;
      end
   end

   // Stall is taken from the registered scoreboard, so it stays high through
   // the cycle the releasing write is presented and drops once the register
   // file already holds the value: ID can use a plain read.
   always_comb begin
      hazard_stall_o = rst_i &&
                       ((pending_q[rs1_i] && (rs1_i != '0)) ||
                        (pending_q[rs2_i] && (rs2_i != '0)) ||
                        (id_we_i && pending_q[id_rd_i]));
   end

   assign drain_stall_o = drain_stall_q;
   assign pending_o     = pending_q;
   assign fifo_count_o  = fifo_count;

   // The pipeline must free the port while a forced drain is signalled.
   a_no_wb_during_drain : assert property (@(posedge clk_i) disable iff (!rst_i)
      !(drain_stall_q && wb_we_i));

   // Re-issuing to a pending register is illegal unless its result is
   // being written in this very cycle.
   a_no_issue_to_pending : assert property (@(posedge clk_i) disable iff (!rst_i)
      !(lu_issue_i && (lu_issue_rd_i != '0) && pending_q[lu_issue_rd_i] &&
        !(lu_wr && (rf_rd_o == lu_issue_rd_i))));

endmodule : rf_write_arbiter
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_rf_write_arbiter                                      |
// | Purpose : Directed self-checking bench for rf_write_arbiter with   |
// |           hand-computed expected values.                           |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_rf_write_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        wb_we_i;
   logic [4:0]  wb_rd_i;
   logic [31:0] wb_data_i;
   logic        lu_issue_i;
   logic [4:0]  lu_issue_rd_i;
   logic        lu_valid_i;
   logic [4:0]  lu_rd_i;
   logic [31:0] lu_data_i;
   logic        lu_ready_o;
   logic [4:0]  rs1_i;
   logic [4:0]  rs2_i;
   logic        id_we_i;
   logic [4:0]  id_rd_i;
   logic        rf_we_o;
   logic [4:0]  rf_rd_o;
   logic [31:0] rf_wdata_o;
   logic        hazard_stall_o;
   logic        drain_stall_o;
   logic [31:0] pending_o;
   logic [1:0]  fifo_count_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   rf_write_arbiter #(
      .FIFO_DEPTH     (2),
      .STARVE_LIMIT   (4)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .wb_we_i        (wb_we_i),
      .wb_rd_i        (wb_rd_i),
      .wb_data_i      (wb_data_i),
      .lu_issue_i     (lu_issue_i),
      .lu_issue_rd_i  (lu_issue_rd_i),
      .lu_valid_i     (lu_valid_i),
      .lu_rd_i        (lu_rd_i),
      .lu_data_i      (lu_data_i),
      .lu_ready_o     (lu_ready_o),
      .rs1_i          (rs1_i),
      .rs2_i          (rs2_i),
      .id_we_i        (id_we_i),
      .id_rd_i        (id_rd_i),
      .rf_we_o        (rf_we_o),
      .rf_rd_o        (rf_rd_o),
      .rf_wdata_o     (rf_wdata_o),
      .hazard_stall_o (hazard_stall_o),
      .drain_stall_o  (drain_stall_o),
      .pending_o      (pending_o),
      .fifo_count_o   (fifo_count_o)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic idle_inputs();
      wb_we_i       = 1'b0;  wb_rd_i   = '0;  wb_data_i = '0;
      lu_issue_i    = 1'b0;  lu_issue_rd_i = '0;
      lu_valid_i    = 1'b0;  lu_rd_i   = '0;  lu_data_i = '0;
      rs1_i = '0;  rs2_i = '0;  id_we_i = 1'b0;  id_rd_i = '0;
   endtask

   // Inputs change just after the rising edge; outputs are read at the falling edge.
   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic sample();
      @(negedge clk_i);
   endtask

   initial begin
      // ---------------- reset state, with busy inputs ----------------
      rst_i = 1'b0;
      idle_inputs();
      wb_we_i = 1'b1; wb_rd_i = 5'd3;
      lu_valid_i = 1'b1; lu_rd_i = 5'd7;
      lu_issue_i = 1'b1; lu_issue_rd_i = 5'd6;
      rs1_i = 5'd6;
      repeat (2) @(posedge clk_i);
      sample();
      chk("rst_rf_we",     32'(rf_we_o),        32'd0);
      chk("rst_lu_ready",  32'(lu_ready_o),     32'd0);
      chk("rst_hazard",    32'(hazard_stall_o), 32'd0);
      chk("rst_drain",     32'(drain_stall_o),  32'd0);
      chk("rst_pending",   pending_o,           32'd0);
      chk("rst_count",     32'(fifo_count_o),   32'd0);
      next_cycle();
      rst_i = 1'b1;
      idle_inputs();

      // ---------------- bypass ----------------
      lu_issue_i = 1'b1; lu_issue_rd_i = 5'd5;
      sample();
      chk("byp_issue_nostall", 32'(hazard_stall_o), 32'd0);
      next_cycle();
      lu_issue_i = 1'b0;
      lu_valid_i = 1'b1; lu_rd_i = 5'd5; lu_data_i = 32'hDEAD_BEEF;
      sample();
      chk("byp_pending_set", pending_o,          32'h0000_0020);
      chk("byp_rf_we",       32'(rf_we_o),       32'd1);
      chk("byp_rf_rd",       32'(rf_rd_o),       32'd5);
      chk("byp_rf_wdata",    rf_wdata_o,         32'hDEAD_BEEF);
      next_cycle();
      lu_valid_i = 1'b0;
      sample();
      chk("byp_pending_clr", pending_o,          32'd0);
      chk("byp_count",       32'(fifo_count_o),  32'd0);
      chk("byp_idle_we",     32'(rf_we_o),       32'd0);
      next_cycle();

      // ---------------- priority + forced drain ----------------
      lu_issue_i = 1'b1; lu_issue_rd_i = 5'd9;
      sample();
      next_cycle();
      lu_issue_i = 1'b0;
      wb_we_i = 1'b1; wb_rd_i = 5'd3; wb_data_i = 32'd7;
      lu_valid_i = 1'b1; lu_rd_i = 5'd9; lu_data_i = 32'h99;
      sample();
      chk("pri0_rf_rd",    32'(rf_rd_o),       32'd3);
      chk("pri0_rf_wdata", rf_wdata_o,         32'd7);
      chk("pri0_count",    32'(fifo_count_o),  32'd0);
      chk("pri0_ready",    32'(lu_ready_o),    32'd1);
      next_cycle();
      lu_data_i = 32'h9A;
      sample();
      chk("pri1_count",    32'(fifo_count_o),  32'd1);
      chk("pri1_rf_rd",    32'(rf_rd_o),       32'd3);
      chk("pri1_drain",    32'(drain_stall_o), 32'd0);
      next_cycle();
      lu_valid_i = 1'b0;
      sample();
      chk("pri2_count",    32'(fifo_count_o),  32'd2);
      chk("pri2_ready",    32'(lu_ready_o),    32'd0);
      chk("pri2_rf_rd",    32'(rf_rd_o),       32'd3);
      next_cycle();
      sample();
      chk("pri3_drain",    32'(drain_stall_o), 32'd0);
      chk("pri3_rf_rd",    32'(rf_rd_o),       32'd3);
      next_cycle();
      wb_we_i = 1'b0;
      sample();
      chk("drn_drain",     32'(drain_stall_o), 32'd1);
      chk("drn_rf_rd",     32'(rf_rd_o),       32'd9);
      chk("drn_rf_wdata",  rf_wdata_o,         32'h99);
      chk("drn_pending",   pending_o,          32'h0000_0200);
      next_cycle();
      wb_we_i = 1'b1;
      sample();
      chk("drn_after",     32'(drain_stall_o), 32'd0);
      chk("drn_count",     32'(fifo_count_o),  32'd1);
      chk("drn_pend_clr",  pending_o,          32'd0);
      chk("drn_wb_rd",     32'(rf_rd_o),       32'd3);
      next_cycle();
      wb_we_i = 1'b0;
      sample();
      chk("fifo_drain_rd",    32'(rf_rd_o),    32'd9);
      chk("fifo_drain_wdata", rf_wdata_o,      32'h9A);
      next_cycle();
      sample();
      chk("fifo_empty_count", 32'(fifo_count_o), 32'd0);
      chk("fifo_empty_we",    32'(rf_we_o),      32'd0);
      next_cycle();
      idle_inputs();

      // ---------------- hazard ----------------
      lu_issue_i = 1'b1; lu_issue_rd_i = 5'd10;
      sample();
      chk("haz_issue_cycle", 32'(hazard_stall_o), 32'd0);
      next_cycle();
      lu_issue_i = 1'b0;
      rs1_i = 5'd10;
      sample();
      chk("haz_rs1",  32'(hazard_stall_o), 32'd1);
      rs1_i = 5'd0; rs2_i = 5'd10; #1;
      chk("haz_rs2",  32'(hazard_stall_o), 32'd1);
      rs2_i = 5'd0; #1;
      chk("haz_x0",   32'(hazard_stall_o), 32'd0);
      id_we_i = 1'b1; id_rd_i = 5'd10; #1;
      chk("haz_waw",  32'(hazard_stall_o), 32'd1);
      id_we_i = 1'b0; id_rd_i = 5'd0;
      next_cycle();
      rs1_i = 5'd10;
      lu_valid_i = 1'b1; lu_rd_i = 5'd10; lu_data_i = 32'hA;
      sample();
      chk("haz_hold_on_write", 32'(hazard_stall_o), 32'd1);
      chk("haz_write_rd",      32'(rf_rd_o),        32'd10);
      next_cycle();
      lu_valid_i = 1'b0;
      sample();
      chk("haz_release", 32'(hazard_stall_o), 32'd0);
      rs1_i = 5'd0; id_we_i = 1'b1; id_rd_i = 5'd0; #1;
      chk("haz_x0_clear", 32'(hazard_stall_o), 32'd0);
      next_cycle();
      idle_inputs();

      // ---------------- set/clear collision ----------------
      lu_issue_i = 1'b1; lu_issue_rd_i = 5'd4;
      sample();
      next_cycle();
      lu_valid_i = 1'b1; lu_rd_i = 5'd4; lu_data_i = 32'h44;
      sample();
      chk("col_rf_rd", 32'(rf_rd_o), 32'd4);
      next_cycle();
      lu_issue_i = 1'b0; lu_valid_i = 1'b0;
      sample();
      chk("col_pending", pending_o, 32'h0000_0010);
      next_cycle();
      lu_valid_i = 1'b1;
      sample();
      next_cycle();
      lu_valid_i = 1'b0;
      sample();
      chk("col_cleared", pending_o, 32'd0);
      next_cycle();

      // ---------------- mid-operation reset ----------------
      lu_issue_i = 1'b1; lu_issue_rd_i = 5'd9;
      sample();
      next_cycle();
      lu_issue_rd_i = 5'd10;
      sample();
      next_cycle();
      lu_issue_i = 1'b0;
      wb_we_i = 1'b1; wb_rd_i = 5'd3; wb_data_i = 32'd7;
      lu_valid_i = 1'b1; lu_rd_i = 5'd9; lu_data_i = 32'h90;
      sample();
      next_cycle();
      lu_rd_i = 5'd10; lu_data_i = 32'hA0;
      sample();
      next_cycle();
      lu_valid_i = 1'b0;
      sample();
      chk("mrst_pre_count",   32'(fifo_count_o), 32'd2);
      chk("mrst_pre_pending", pending_o,         32'h0000_0600);
      rst_i = 1'b0; #1;
      chk("mrst_low_we",    32'(rf_we_o),    32'd0);
      chk("mrst_low_ready", 32'(lu_ready_o), 32'd0);
      next_cycle();
      sample();
      chk("mrst_count",   32'(fifo_count_o),  32'd0);
      chk("mrst_pending", pending_o,          32'd0);
      chk("mrst_we",      32'(rf_we_o),       32'd0);
      chk("mrst_ready",   32'(lu_ready_o),    32'd0);
      chk("mrst_drain",   32'(drain_stall_o), 32'd0);
      next_cycle();
      rst_i = 1'b1;
      idle_inputs();
      sample();
      chk("mrst_ready_back", 32'(lu_ready_o),   32'd1);
      chk("mrst_count_back", 32'(fifo_count_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_rf_write_arbiter
`default_nettype wire
